// File: rtl/aegnn_pkg.sv
// Shared AEGNN datapath types: accumulator and feature widths.
package aegnn_pkg;

    localparam int ACC_W = 24;
    localparam int F_W   = 8;

    typedef logic signed [ACC_W-1:0] accum_t;
    typedef logic        [F_W-1:0]   f_t;

endpackage

// File: rtl/requant_fifo.sv
// Small synchronous FIFO holding requantized results; registered head, sync clear.
module requant_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mac_requant.sv
// Bias add, shift, ReLU/clamp requantizer with a 4-deep credit-managed output FIFO.
// Define REQUANT_ROUND_EN for round-half-up before the shift; default truncates.
module mac_requant
    import aegnn_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int SHIFT  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  accum_t                    in_accum,
    input  accum_t                    in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output f_t                        out_feature,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      out_sat
);

    localparam int CH_W       = $clog2(NUM_CH);
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PAY_W      = 1 + CH_W + F_W;
    localparam int F_MAX_I    = (1 << F_W) - 1;
    localparam logic signed [ACC_W+1:0] F_MAX = $signed((ACC_W + 2)'(F_MAX_I));
`ifdef REQUANT_ROUND_EN
    localparam logic signed [ACC_W+1:0] ROUND_ADD = $signed((ACC_W + 2)'(1 << (SHIFT - 1)));
`endif

    logic signed [ACC_W:0]   s1_sum;
    logic                    s1_valid;
    logic [CH_W-1:0]         s1_ch;
    logic [CH_W-1:0]         ch_cnt;
    logic                    accept;

    logic signed [ACC_W+1:0] rsum;
    logic signed [ACC_W+1:0] shifted;
    f_t                      s2_feature;
    logic                    s2_sat;

    logic [PAY_W-1:0]        fifo_dout;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_sat;
    logic [CH_W-1:0]         head_ch;
    f_t                      head_feature;
    logic [CNT_W:0]          credit_used;

    assign accept = in_valid && in_ready && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
            ch_cnt   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= {in_accum[ACC_W-1], in_accum} + {in_bias[ACC_W-1], in_bias};
                s1_ch  <= ch_cnt;
            end
            if (clear)
                ch_cnt <= '0;
            else if (accept)
                ch_cnt <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
        end
    end

    // S2 is computed from S1 and registered directly as the FIFO entry,
    // which gives the two-edge latency from acceptance to out_valid.
    always_comb begin
        rsum = {s1_sum[ACC_W], s1_sum};
`ifdef REQUANT_ROUND_EN
        rsum = rsum + ROUND_ADD;
`endif
        shifted    = rsum >>> SHIFT;
        s2_feature = '0;
        s2_sat     = 1'b0;
        if (shifted[ACC_W+1]) begin
            s2_feature = '0;
        end else if (shifted > F_MAX) begin
            s2_feature = '1;
            s2_sat     = 1'b1;
        end else begin
            s2_feature = shifted[F_W-1:0];
        end
    end

    requant_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (s1_valid && !clear),
        .din   ({s2_sat, s1_ch, s2_feature}),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credits count everything already committed downstream, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid);
    assign in_ready    = !rst && !fifo_full && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    assign {head_sat, head_ch, head_feature} = fifo_dout;

    assign out_valid   = !rst && !fifo_empty;
    assign out_feature = out_valid ? head_feature : '0;
    assign out_ch      = out_valid ? head_ch : '0;
    assign out_sat     = out_valid && head_sat;
    assign out_last    = out_valid && (head_ch == CH_W'(NUM_CH - 1));

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant (NUM_CH=4, SHIFT=4) with a queue-based reference model.
module tb_mac_requant;
    import aegnn_pkg::*;

    localparam int NCH   = 4;
    localparam int SH    = 4;
    localparam int PW    = 1 << SH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    accum_t     in_accum = '0;
    accum_t     in_bias = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    f_t         out_feature;
    logic [1:0] out_ch;
    logic       out_last;
    logic       out_sat;

    typedef struct {
        int feature;
        int ch;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   model_ch = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;

    mac_requant #(.NUM_CH(NCH), .SHIFT(SH)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_accum    (in_accum),
        .in_bias     (in_bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_feature (out_feature),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Requantization rule from plain integer arithmetic: floor division then clamp.
    function automatic exp_t model(input longint s, input int ch);
        exp_t   e;
        longint q;
`ifdef REQUANT_ROUND_EN
        s = s + PW / 2;
`endif
        if (s >= 0) q = s / PW;
        else        q = -((-s + PW - 1) / PW);
        e.ch = ch;
        e.sat = 1'b0;
        if (q < 0)        e.feature = 0;
        else if (q > 255) begin e.feature = 255; e.sat = 1'b1; end
        else              e.feature = int'(q);
        return e;
    endfunction

    // Handshakes are judged at the falling edge, where all inputs are settled for the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pop: observed out_valid=1 expected 0");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mon_feature", 32'(out_feature), 32'(e.feature));
                    chk("mon_ch", 32'(out_ch), 32'(e.ch));
                    chk("mon_sat", 32'(out_sat), 32'(e.sat));
                    chk("mon_last", 32'(out_last), 32'(e.ch == NCH - 1));
                end
                n_pop++;
            end
            if (clear) begin
                exp_q.delete();
                model_ch = 0;
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(longint'(in_accum) + longint'(in_bias), model_ch));
                model_ch = (model_ch + 1) % NCH;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int a, input int b);
        in_valid = v;
        in_accum = accum_t'(a);
        in_bias  = accum_t'(b);
    endtask

    function automatic int rand_val();
        logic [23:0] r;
        int          a;
        case ($urandom_range(0, 3))
            0:       a = int'($urandom_range(0, 8000)) - 4000;
            1:       a = 3000 + int'($urandom_range(0, 10000));
            2:       a = int'($urandom_range(0, 4095));
            default: begin r = 24'($urandom); a = int'($signed(r)); end
        endcase
        return a;
    endfunction

    initial begin
        int acc_cnt;
        int pops0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_feature", 32'(out_feature), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Rounding and two-cycle latency
        tick();
        drive(1, 168, 0);
        tick();
        drive(0, 0, 0);
        chk("lat_n1_valid", 32'(out_valid), 0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 1);
`ifdef REQUANT_ROUND_EN
        chk("round_feature", 32'(out_feature), 11);
`else
        chk("round_feature", 32'(out_feature), 10);
`endif
        tick();

        // Clamp low and high
        drive(1, -500, 20);
        tick();
        drive(1, 5000, 0);
        tick();
        drive(0, 0, 0);
        chk("clamp_neg_feature", 32'(out_feature), 0);
        chk("clamp_neg_sat", 32'(out_sat), 0);
        tick();
        chk("clamp_pos_feature", 32'(out_feature), 255);
        chk("clamp_pos_sat", 32'(out_sat), 1);
        tick();

        // Channel tagging at full rate, starting from a cleared counter
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                drive(1, rand_val(), int'($urandom_range(0, 200)));
                chk("tag_in_ready", 32'(in_ready), 1);
            end else begin
                drive(0, 0, 0);
            end
            if (i >= 2) begin
                chk("tag_valid", 32'(out_valid), 1);
                chk("tag_ch", 32'(out_ch), 32'((i - 2) % NCH));
                chk("tag_last", 32'(out_last), 32'((i - 2) == NCH - 1));
            end
            tick();
        end
        tick();

        // Backpressure: only four beats fit downstream
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, rand_val(), int'($urandom_range(0, 50)));
            #1;
            if (in_ready) acc_cnt++;
            if (i >= 5) begin
                chk("bp_hold_valid", 32'(out_valid), 1);
                chk("bp_hold_feature", 32'(out_feature), 32'(exp_q[0].feature));
                chk("bp_hold_ch", 32'(out_ch), 32'(exp_q[0].ch));
            end
            tick();
        end
        chk("bp_accepted", 32'(acc_cnt), 4);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        drive(0, 0, 0);
        pops0 = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_drained_count", 32'(n_pop - pops0), 4);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);

        // Clear with three beats in flight; the beat offered alongside clear is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_val(), 0);
            tick();
        end
        clear = 1'b1;
        drive(1, 1234, 0);
        tick();
        clear = 1'b0;
        drive(0, 0, 0);
        chk("clr_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        drive(1, 800, 0);
        chk("clr_in_ready", 32'(in_ready), 1);
        tick();
        drive(0, 0, 0);
        tick();
        chk("clr_next_valid", 32'(out_valid), 1);
        chk("clr_next_ch", 32'(out_ch), 0);
        tick();

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_val(), int'($urandom_range(0, 2000)) - 1000);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rand_queue_empty", 32'(exp_q.size()), 0);
        chk("rand_out_valid_idle", 32'(out_valid), 0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++) begin
            drive(1, rand_val(), 0);
            tick();
        end
        chk("arst_pre_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_out_feature", 32'(out_feature), 0);
        exp_q.delete();
        model_ch = 0;
        drive(0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_release_in_ready", 32'(in_ready), 1);
        drive(1, 300, 0);
        tick();
        drive(0, 0, 0);
        tick();
        chk("arst_first_valid", 32'(out_valid), 1);
        chk("arst_first_ch", 32'(out_ch), 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
